// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle signed multiply/divide unit.
// Default operand width, op codes, FSM encoding and iteration sizing helpers.
package mult_div_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } md_state_e;

    // One result bit per cycle, so the iteration count equals the operand width.
    function automatic int unsigned iter_count(int unsigned width);
        return width;
    endfunction

    function automatic int unsigned cnt_width(int unsigned width);
        return (iter_count(width) > 1) ? $clog2(iter_count(width)) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           dividend_bit,
    input  logic [WIDTH:0] divisor,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    localparam int unsigned RemW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // The kept remainder is always below the divisor, so it fits in WIDTH+1 bits.
    assign rem_out = RemW'(q_bit ? diff : shifted);

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit feeding Hi/Lo.
// One result bit per cycle; hi/lo are only written on the final iteration.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(iter_count(WIDTH) - 1);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             op_q, op_d;
    // acc: Booth accumulator or partial remainder; sr: multiplier or dividend/quotient.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             q1_q, q1_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   booth_sum, booth_acc;
    logic [WIDTH-1:0] booth_sr;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_mag, rem_mag;

    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        unique case ({sr_q[0], q1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
    end

    // Arithmetic shift right of {acc, multiplier, q-1}.
    assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_sr  = {booth_sum[0], sr_q[WIDTH-1:1]};

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in      (acc_q),
        .dividend_bit(sr_q[WIDTH-1]),
        .divisor     (mcand_q),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    assign quo_mag = {sr_q[WIDTH-2:0], step_q};
    assign rem_mag = step_rem[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        q1_d      = q1_q;
        mcand_d   = mcand_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                dz_d = 1'b0;
                if (start) begin
                    if (op == OP_DIV && b == '0) begin
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        op_d    = op;
                        cnt_d   = '0;
                        acc_d   = '0;
                        q1_d    = 1'b0;
                        state_d = StRun;
                        if (op == OP_MULT) begin
                            sr_d    = b;
                            mcand_d = {a[WIDTH-1], a};
                        end else begin
                            sr_d      = a_mag;
                            mcand_d   = {1'b0, b_mag};
                            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem_d = a[WIDTH-1];
                        end
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MULT) begin
                    acc_d = booth_acc;
                    sr_d  = booth_sr;
                    q1_d  = sr_q[0];
                end else begin
                    acc_d = step_rem;
                    sr_d  = quo_mag;
                end
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    if (op_q == OP_MULT) begin
                        hi_d = booth_acc[WIDTH-1:0];
                        lo_d = booth_sr;
                    end else begin
                        hi_d = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
                        lo_d = neg_quo_q ? (~quo_mag + 1'b1) : quo_mag;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            sr_q      <= '0;
            q1_q      <= 1'b0;
            mcand_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            q1_q      <= q1_d;
            mcand_q   <= mcand_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign div_zero = (state_q == StDone) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit with a scoreboard of expected results.
module tb_mult_div_unit;

    localparam logic TB_MULT = 1'b0;
    localparam logic TB_DIV  = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic, truncating division, remainder signed like a.
    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint      sx, sy;
        logic [63:0] p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == TB_MULT) begin
            p  = 64'(sx * sy);
            eh = p[63:32];
            el = p[31:0];
        end else begin
            q  = 64'(sx / sy);
            r  = 64'(sx % sy);
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    // Starts an op at the next falling edge (cycle 0) and returns at the done cycle.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input int elat, input string tag, input bit inject);
        exp_t e;
        int   lat;
        int   busy_low;
        sb.push_back('{hi: eh, lo: el, dz: edz, lat: elat});
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat      = -1;
        busy_low = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                op = ~o;
                a  = $urandom;
                b  = $urandom;
            end
            if (inject && (k == 5 || k == 20)) begin
                start = 1'b1;
                op    = TB_DIV;
                a     = 32'd100;
                b     = 32'd7;
            end
            if (k == 6 || k == 21) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_low++;
        end
        e = sb.pop_front();
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".busy_low_cycles"}, 64'(busy_low), 64'd0);
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, e.lo});
        check({tag, ".div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".done_after"}, {63'd0, done}, 64'd0);
        check({tag, ".busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_model(input logic o, input logic [31:0] x, input logic [31:0] y,
                             input string tag);
        logic [31:0] eh, el;
        model(o, x, y, eh, el);
        run_op(o, x, y, eh, el, 1'b0, 33, tag, 1'b0);
        idle_check(tag);
    endtask

    initial begin
        int          n_done;
        logic        ro;
        logic [31:0] rx, ry;

        reset = 1'b1;
        start = 1'b0;
        op    = TB_MULT;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset.hi", {32'd0, hi}, 64'd0);
        check("reset.lo", {32'd0, lo}, 64'd0);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b0;

        run_op(TB_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33,
               "mult_7x-3", 1'b0);
        idle_check("mult_7x-3");
        run_op(TB_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33,
               "mult_max", 1'b0);
        idle_check("mult_max");
        run_op(TB_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33,
               "mult_min", 1'b0);
        idle_check("mult_min");
        run_op(TB_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33,
               "div_-7/2", 1'b0);
        idle_check("div_-7/2");
        run_op(TB_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33,
               "div_7/-2", 1'b0);
        idle_check("div_7/-2");
        run_op(TB_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33,
               "div_min/-1", 1'b0);
        idle_check("div_min/-1");

        // Product 0x11111111_22222222 sets up the divide-by-zero hold check.
        run_model(TB_MULT, 32'h3333_3333, 32'h5555_5556, "mult_seed");
        run_op(TB_DIV, 32'd5, 32'd0, prev_hi, prev_lo, 1'b1, 1, "div_by_zero", 1'b0);
        idle_check("div_by_zero");

        run_op(TB_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, "mult_ignore_start", 1'b1);
        run_model(TB_MULT, 32'hFFFF_FFFB, 32'd6, "mult_back_to_back");

        // Asynchronous reset in the middle of cycle 10 of a multiply.
        @(negedge clk);
        start = 1'b1;
        op    = TB_MULT;
        a     = 32'd3;
        b     = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("async_reset.hi", {32'd0, hi}, 64'd0);
        check("async_reset.lo", {32'd0, lo}, 64'd0);
        check("async_reset.busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("async_reset.no_done", 64'(n_done), 64'd0);
        run_model(TB_MULT, 32'hFFFF_FFF8, 32'd9, "mult_after_reset");

        for (int i = 0; i < 6; i++) begin
            ro = (i % 2 == 1) ? TB_DIV : TB_MULT;
            rx = $urandom;
            ry = $urandom;
            if (i >= 4) ry = ry >> 20;
            if (ro == TB_DIV && ry == 0) ry = 32'd1;
            run_model(ro, rx, ry, (ro == TB_DIV) ? "rand_div" : "rand_mult");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
